i2c_bus_conditioner: RTL and testbench

//  - Front end for the I2C slave. Sits between the SCL/SDA pads and the slave's bit engine.
//  - Synchronises raw SCL/SDA to in_clk and rejects glitches.
//  - Produces one-cycle SCL edge strobes and START/STOP strobes, plus a bus-busy flag.
//  - Lets the slave run purely on clean, single-clock-domain events.

---
 rtl/i2c_pkg.sv | 13 +
 rtl/i2c_glitch_filter.sv | 52 +++++
 rtl/i2c_bus_conditioner.sv | 122 ++++++++++++
 tb/tb_i2c_bus_conditioner.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: bus-state encoding and default conditioner timing constants.
package i2c_pkg;

    typedef enum logic {
        I2C_BUS_IDLE = 1'b0,
        I2C_BUS_BUSY = 1'b1
    } i2c_bus_state_e;

    localparam int unsigned I2C_SYNC_STAGES    = 2;
    localparam int unsigned I2C_FILTER_CYCLES  = 4;
    localparam int unsigned I2C_TIMEOUT_CYCLES = 1000000;

endpackage

// File: rtl/i2c_glitch_filter.sv
// Synchroniser plus stability counter for one open-drain line; no backpressure.
// Latency SYNC_STAGES+FILTER_CYCLES cycles; chg_o flags the cycle before filt_o flips.
module i2c_glitch_filter
    import i2c_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = I2C_SYNC_STAGES,
    parameter int unsigned FILTER_CYCLES = I2C_FILTER_CYCLES
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic raw_i,
    output logic filt_o,
    output logic chg_o
);
    localparam int unsigned CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic                   filt_q, filt_d;
    logic [CW-1:0]          cnt_q, cnt_d;

    assign synced = sync_q[SYNC_STAGES-1];
    assign filt_o = filt_q;

    // Counter only survives consecutive disagreeing cycles; any agreement restarts it.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        chg_o  = 1'b0;
        if (synced != filt_q) begin
            if (cnt_q == CW'(FILTER_CYCLES - 1)) begin
                filt_d = synced;
                chg_o  = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '1;
            filt_q <= 1'b1;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/i2c_bus_conditioner.sv
// Clean SCL/SDA levels, SCL edge strobes, START/STOP strobes and bus-busy for the I2C slave; no backpressure.
// Strobes follow the filtered lines by 0 (edges) or 1 (START/STOP) cycle; I2C_COND_TIMEOUT_EN adds a stuck-SCL timeout.
module i2c_bus_conditioner
    import i2c_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = I2C_SYNC_STAGES,
    parameter int unsigned FILTER_CYCLES  = I2C_FILTER_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = I2C_TIMEOUT_CYCLES
) (
    input  logic in_clk,
    input  logic in_rst_n,
    input  logic in_scl,
    input  logic in_sda,
    output logic out_scl,
    output logic out_sda,
    output logic out_scl_rise,
    output logic out_scl_fall,
    output logic out_start,
    output logic out_stop,
    output logic out_bus_busy,
    output logic out_timeout
);
    i2c_bus_state_e state_q, state_d;

    logic scl_f, sda_f, scl_chg, sda_chg_unused;
    logic scl_prev_q, sda_prev_q;
    logic rise_q, fall_q, start_q, stop_q;
    logic start_det, stop_det, tmo_hit;

    i2c_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_CYCLES(FILTER_CYCLES)) u_scl_filt (
        .clk_i(in_clk), .rst_n_i(in_rst_n), .raw_i(in_scl), .filt_o(scl_f), .chg_o(scl_chg)
    );

    i2c_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_CYCLES(FILTER_CYCLES)) u_sda_filt (
        .clk_i(in_clk), .rst_n_i(in_rst_n), .raw_i(in_sda), .filt_o(sda_f), .chg_o(sda_chg_unused)
    );

    // SCL must be high in both samples, so a simultaneous SCL/SDA change is ignored.
    assign start_det =  sda_prev_q & ~sda_f & scl_prev_q & scl_f;
    assign stop_det  = ~sda_prev_q &  sda_f & scl_prev_q & scl_f;

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            scl_prev_q <= scl_f;
            sda_prev_q <= sda_f;
            rise_q     <= scl_chg & ~scl_f;
            fall_q     <= scl_chg &  scl_f;
            start_q    <= start_det;
            stop_q     <= stop_det;
        end
    end

`ifdef I2C_COND_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          scl_low_busy, timeout_q;

    assign scl_low_busy = (state_q == I2C_BUS_BUSY) && !scl_f;
    assign tmo_hit      = scl_low_busy && (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
    assign out_timeout  = timeout_q;

    always_comb begin
        tmo_cnt_d = '0;
        if (scl_low_busy) begin
            tmo_cnt_d = (tmo_cnt_q == TW'(TIMEOUT_CYCLES)) ? tmo_cnt_q : tmo_cnt_q + TW'(1);
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= tmo_hit;
        end
    end
`else
    logic unused_tmo;

    assign unused_tmo  = |TIMEOUT_CYCLES;
    assign tmo_hit     = 1'b0;
    assign out_timeout = 1'b0;
`endif

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q <= I2C_BUS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            I2C_BUS_IDLE: if (start_det) state_d = I2C_BUS_BUSY;
            I2C_BUS_BUSY: if (stop_det || tmo_hit) state_d = I2C_BUS_IDLE;
            default:      state_d = I2C_BUS_IDLE;
        endcase
    end

    always_comb begin
        out_bus_busy = (state_q == I2C_BUS_BUSY);
    end

    assign out_scl      = scl_f;
    assign out_sda      = sda_f;
    assign out_scl_rise = rise_q;
    assign out_scl_fall = fall_q;
    assign out_start    = start_q;
    assign out_stop     = stop_q;

endmodule

// File: tb/tb_i2c_bus_conditioner.sv
// Bench for i2c_bus_conditioner: directed bus scenarios plus random pad activity
// compared each cycle against a sample-history model of the bus rules.
module tb_i2c_bus_conditioner;
    localparam int SYNC = 2;
    localparam int FILT = 4;
    localparam int TMO  = 100;
    localparam int HN   = SYNC + FILT;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic scl   = 1'b1;
    logic sda   = 1'b1;
    logic o_scl, o_sda, o_rise, o_fall, o_start, o_stop, o_busy, o_tmo;

    int n_chk  = 0;
    int n_fail = 0;
    int c_rise = 0, c_fall = 0, c_start = 0, c_stop = 0, c_tmo = 0;

    always #5 clk = ~clk;

    i2c_bus_conditioner #(
        .SYNC_STAGES(SYNC), .FILTER_CYCLES(FILT), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .in_clk(clk), .in_rst_n(rst_n), .in_scl(scl), .in_sda(sda),
        .out_scl(o_scl), .out_sda(o_sda), .out_scl_rise(o_rise), .out_scl_fall(o_fall),
        .out_start(o_start), .out_stop(o_stop), .out_bus_busy(o_busy), .out_timeout(o_tmo)
    );

    // Reference: a line level is accepted once FILT consecutive synchronised samples
    // disagree with the current level; events are read off the accepted-level history.
    logic [HN-1:0] h_scl, h_sda;
    logic [2:0]    fs_scl, fs_sda;
    logic          e_rise, e_fall, e_start, e_stop, e_busy, e_tmo;
`ifdef I2C_COND_TIMEOUT_EN
    int            low_run;
`endif

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_scl = '1; h_sda = '1; fs_scl = '1; fs_sda = '1;
            e_rise = 0; e_fall = 0; e_start = 0; e_stop = 0; e_busy = 0; e_tmo = 0;
`ifdef I2C_COND_TIMEOUT_EN
            low_run = 0;
`endif
        end else begin
            h_scl  = {h_scl[HN-2:0], scl};
            h_sda  = {h_sda[HN-2:0], sda};
            fs_scl = {fs_scl[1:0], (h_scl[SYNC +: FILT] == {FILT{~fs_scl[0]}}) ? ~fs_scl[0] : fs_scl[0]};
            fs_sda = {fs_sda[1:0], (h_sda[SYNC +: FILT] == {FILT{~fs_sda[0]}}) ? ~fs_sda[0] : fs_sda[0]};
            e_rise  =  fs_scl[0] & ~fs_scl[1];
            e_fall  = ~fs_scl[0] &  fs_scl[1];
            e_start =  fs_sda[2] & ~fs_sda[1] & fs_scl[2] & fs_scl[1];
            e_stop  = ~fs_sda[2] &  fs_sda[1] & fs_scl[2] & fs_scl[1];
            e_tmo   = 0;
`ifdef I2C_COND_TIMEOUT_EN
            low_run = (e_busy && !fs_scl[1]) ? low_run + 1 : 0;
            if (low_run == TMO) e_tmo = 1;
`endif
            if (e_start) e_busy = 1;
            else if (e_stop || e_tmo) e_busy = 0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_chk, n_fail);
        $fatal(1, "watchdog expired");
    end

    task automatic drive(input logic s_scl, input logic s_sda, input int n);
        scl = s_scl;
        sda = s_sda;
        repeat (n) begin
            @(negedge clk);
            if (o_rise  === 1'b1) c_rise++;
            if (o_fall  === 1'b1) c_fall++;
            if (o_start === 1'b1) c_start++;
            if (o_stop  === 1'b1) c_stop++;
            if (o_tmo   === 1'b1) c_tmo++;
        end
    endtask

    task automatic test_reset();
        logic [7:0] got;
        rst_n = 1'b0; scl = 1'b1; sda = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({o_scl, o_sda} !== 2'b11) begin
            n_fail++; $display("FAIL reset_lines: got %b, want 11", {o_scl, o_sda});
        end
        n_chk++;
        if (o_busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b, want 0", o_busy);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            got = {o_scl, o_sda, o_rise, o_fall, o_start, o_stop, o_busy, o_tmo};
            n_chk++;
            if (got !== 8'b1100_0000) begin
                n_fail++; $display("FAIL reset_idle cycle %0d: got %b, want 11000000", i, got);
            end
        end
    endtask

    task automatic test_start_latency();
        int s0;
        sda = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            n_chk++;
            if (o_start !== 1'(i == 7)) begin
                n_fail++; $display("FAIL start_latency cycle %0d: got %b, want %b", i, o_start, i == 7);
            end
            n_chk++;
            if (o_busy !== 1'(i >= 7)) begin
                n_fail++; $display("FAIL start_busy cycle %0d: got %b, want %b", i, o_busy, i >= 7);
            end
            n_chk++;
            if (o_sda !== 1'(i < 6)) begin
                n_fail++; $display("FAIL sda_latency cycle %0d: got %b, want %b", i, o_sda, i < 6);
            end
        end
        s0 = c_stop;
        drive(1, 1, 12);
        n_chk++;
        if (c_stop - s0 != 1 || o_busy !== 1'b0) begin
            n_fail++; $display("FAIL stop_after_start: stops %0d busy %b, want 1 and 0", c_stop - s0, o_busy);
        end
    endtask

    task automatic test_glitch();
        logic [2:0] got, want;
        for (int w = 3; w <= 4; w++) begin
            scl = 1'b0;
            for (int i = 1; i <= 16; i++) begin
                @(negedge clk);
                if (i == w) scl = 1'b1;
                got  = {o_scl, o_fall, o_rise};
                want = {(w == 4) ? !(i >= 6 && i <= 9) : 1'b1, 1'(w == 4 && i == 6), 1'(w == 4 && i == 10)};
                n_chk++;
                if (got !== want || o_start !== 1'b0 || o_stop !== 1'b0) begin
                    n_fail++;
                    $display("FAIL glitch_w%0d cycle %0d: scl/fall/rise %b start %b stop %b, want %b 0 0",
                             w, i, got, o_start, o_stop, want);
                end
            end
        end
    endtask

    task automatic test_byte();
        logic [7:0] data;
        int r0, f0, s0, p0;
        data = 8'($urandom);
        drive(1, 1, 10);
        r0 = c_rise; f0 = c_fall; s0 = c_start; p0 = c_stop;
        drive(1, 0, 10);
        for (int b = 0; b < 9; b++) begin
            drive(0, sda, 8);
            drive(0, (b < 8) ? data[7-b] : 1'b0, 8);
            drive(1, sda, 10);
        end
        n_chk++;
        if (o_busy !== 1'b1) begin
            n_fail++; $display("FAIL byte_busy_before_stop: got %b, want 1", o_busy);
        end
        drive(1, 1, 12);
        n_chk++;
        if (c_rise - r0 != 9 || c_fall - f0 != 9) begin
            n_fail++; $display("FAIL byte_edges: rise %0d fall %0d, want 9 9", c_rise - r0, c_fall - f0);
        end
        n_chk++;
        if (c_start - s0 != 1 || c_stop - p0 != 1) begin
            n_fail++; $display("FAIL byte_start_stop: start %0d stop %0d, want 1 1", c_start - s0, c_stop - p0);
        end
        n_chk++;
        if (o_busy !== 1'b0) begin
            n_fail++; $display("FAIL byte_busy_after_stop: got %b, want 0", o_busy);
        end
    endtask

    task automatic test_repeated_start();
        int s0, p0;
        s0 = c_start; p0 = c_stop;
        drive(1, 0, 10);
        drive(0, 0, 10);
        drive(0, 1, 10);
        drive(1, 1, 10);
        sda = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (o_start === 1'b1) c_start++;
            n_chk++;
            if (o_busy !== 1'b1) begin
                n_fail++; $display("FAIL rstart_busy cycle %0d: got %b, want 1", i, o_busy);
            end
        end
        n_chk++;
        if (c_start - s0 != 2) begin
            n_fail++; $display("FAIL rstart_count: got %0d, want 2", c_start - s0);
        end
        s0 = c_start;
        drive(0, 0, 10);
        drive(1, 1, 12);
        drive(0, 0, 12);
        n_chk++;
        if (c_start != s0 || c_stop != p0 || o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL simultaneous: start %0d stop %0d busy %b, want 0 0 1", c_start - s0, c_stop - p0, o_busy);
        end
        drive(1, 0, 10);
        drive(1, 1, 12);
        n_chk++;
        if (c_stop - p0 != 1 || o_busy !== 1'b0) begin
            n_fail++; $display("FAIL rstart_stop: stops %0d busy %b, want 1 0", c_stop - p0, o_busy);
        end
    endtask

    task automatic test_timeout();
        int k;
        drive(1, 0, 10);
        scl = 1'b0;
        k = 0;
        while (o_fall !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        n_chk++;
        if (o_fall !== 1'b1) begin
            n_fail++; $display("FAIL timeout_fall_seen: got %b, want 1 within 20 cycles", o_fall);
        end
`ifdef I2C_COND_TIMEOUT_EN
        for (int d = 1; d <= 110; d++) begin
            @(negedge clk);
            n_chk++;
            if (o_tmo !== 1'(d == TMO) || o_busy !== 1'(d < TMO)) begin
                n_fail++;
                $display("FAIL timeout_pulse cycle %0d: tmo %b busy %b, want %b %b", d, o_tmo, o_busy, d == TMO, d < TMO);
            end
        end
`else
        for (int d = 1; d <= 300; d++) begin
            @(negedge clk);
            n_chk++;
            if (o_tmo !== 1'b0 || o_busy !== 1'b1) begin
                n_fail++; $display("FAIL no_timeout cycle %0d: tmo %b busy %b, want 0 1", d, o_tmo, o_busy);
            end
        end
`endif
        drive(1, 0, 10);
        drive(1, 1, 12);
        n_chk++;
        if (o_busy !== 1'b0) begin
            n_fail++; $display("FAIL timeout_release_busy: got %b, want 0", o_busy);
        end
    endtask

    task automatic test_reset_mid_byte();
        logic [7:0] got;
        drive(1, 0, 10);
        drive(0, 0, 10);
        drive(0, 1, 10);
        drive(1, 1, 10);
        drive(0, 1, 3);
        rst_n = 1'b0; scl = 1'b1; sda = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({o_scl, o_sda, o_busy} !== 3'b110) begin
            n_fail++; $display("FAIL midreset_forced: scl/sda/busy %b, want 110", {o_scl, o_sda, o_busy});
        end
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            got = {o_scl, o_sda, o_rise, o_fall, o_start, o_stop, o_busy, o_tmo};
            n_chk++;
            if (got !== 8'b1100_0000) begin
                n_fail++; $display("FAIL midreset_release cycle %0d: got %b, want 11000000", i, got);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] got, want;
        int len, mode;
        for (int s = 0; s < 500; s++) begin
            mode = $urandom_range(0, 9);
            if (mode < 4) scl = ~scl;
            else if (mode < 8) sda = ~sda;
            else if (mode == 9 && $urandom_range(0, 4) == 0) rst_n = 1'b0;
            else begin
                scl = 1'($urandom_range(0, 1));
                sda = 1'($urandom_range(0, 1));
            end
            len = ($urandom_range(0, 19) == 0) ? $urandom_range(90, 130) : $urandom_range(1, 9);
            for (int i = 0; i < len; i++) begin
                @(negedge clk);
                got  = {o_scl, o_sda, o_rise, o_fall, o_start, o_stop, o_busy, o_tmo};
                want = {fs_scl[0], fs_sda[0], e_rise, e_fall, e_start, e_stop, e_busy, e_tmo};
                n_chk++;
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL random step %0d cycle %0d: scl,sda,rise,fall,start,stop,busy,tmo got %b, want %b",
                             s, i, got, want);
                end
                if (!rst_n) rst_n = 1'b1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_start_latency();
        test_glitch();
        test_byte();
        test_repeated_start();
        test_timeout();
        test_reset_mid_byte();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
